// File: rtl/memport_arbiter_if.sv
// memport_arbiter_if: bundles the fetch port, data port and unified-memory port
// of memport_arbiter.
//   slave  : arbiter view (takes requests and memory responses, drives acks and memory request)
//   master : environment view (requesters and memory model)
// Fetch port  : if_req, if_addr -> if_ack, if_inst
// Data port   : dm_req, dm_we, dm_addr, dm_wdata -> dm_ack, dm_rdata
// Memory port : mem_req, mem_we, mem_addr, mem_wdata -> mem_ack, mem_rdata
// Debug       : grant_dm
interface memport_arbiter_if;
    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned INST_W = 32;

    // Fetch port (read-only)
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [INST_W-1:0] if_inst;

    // Data port (read/write)
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_ack;
    logic [DATA_W-1:0] dm_rdata;

    // Unified memory port
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    // Data-port ownership indicator
    logic              grant_dm;

    modport slave (
        input  if_req, if_addr,
        output if_ack, if_inst,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_ack, dm_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata,
        output grant_dm
    );

    modport master (
        output if_req, if_addr,
        input  if_ack, if_inst,
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_ack, dm_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata,
        input  grant_dm
    );
endinterface

// File: rtl/memport_arbiter.sv
// memport_arbiter: shares one single-ported, variable-latency memory between the
// instruction-fetch port and the data port. One requester is granted at a time;
// the memory request is held until mem_ack, then read data is returned registered
// together with a one-cycle ack pulse. Data wins ties, but after MAXDATA
// consecutive contested data grants the fetch is forced through.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : memport_arbiter_if.slave (fetch, data, memory and grant_dm signals)
module memport_arbiter #(
    parameter int unsigned MAXDATA = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    memport_arbiter_if.slave        bus
);
    localparam int unsigned ADDR_W   = 64;
    localparam int unsigned DATA_W   = 64;
    localparam int unsigned INST_W   = 32;
    localparam int unsigned STREAK_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_DM = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e              state_q,     state_d;
    logic [STREAK_W-1:0] streak_q,    streak_d;
    logic                if_sel_q,    if_sel_d;
    logic                mem_req_q,   mem_req_d;
    logic                mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                if_ack_q,    if_ack_d;
    logic                dm_ack_q,    dm_ack_d;
    logic                grant_dm_q,  grant_dm_d;
    logic [INST_W-1:0]   if_inst_q,   if_inst_d;
    logic [DATA_W-1:0]   dm_rdata_q,  dm_rdata_d;

    logic                streak_at_max;
    logic                unused_addr_bits;

    // Fetch is forced through once the contested data streak reaches the limit
    assign streak_at_max = (streak_q >= STREAK_W'(MAXDATA));

    // Sub-word address bits carry no meaning for a doubleword memory
    assign unused_addr_bits = ^{bus.if_addr[1:0], bus.dm_addr[2:0]};

    // Next-state, grant latching and response formation
    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        if_sel_d    = if_sel_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        grant_dm_d  = grant_dm_q;
        if_inst_d   = if_inst_q;
        dm_rdata_d  = dm_rdata_q;

        case (state_q)
            IDLE: begin
                if (bus.dm_req && !(bus.if_req && streak_at_max)) begin
                    // Data grant: contested grants extend the streak, lone ones do not
                    state_d     = GNT_DM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.dm_we;
                    mem_addr_d  = {bus.dm_addr[ADDR_W-1:3], 3'b000};
                    mem_wdata_d = bus.dm_wdata;
                    grant_dm_d  = 1'b1;
                    if (bus.if_req) begin
                        streak_d = streak_q + STREAK_W'(1);
                    end
                end else if (bus.if_req) begin
                    // Fetch grant: always a read, remembers which word of the doubleword
                    state_d    = GNT_IF;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {bus.if_addr[ADDR_W-1:3], 3'b000};
                    if_sel_d   = bus.if_addr[2];
                    streak_d   = '0;
                    grant_dm_d = 1'b0;
                end
            end

            GNT_IF, GNT_DM: begin
                if (bus.mem_ack) begin
                    state_d    = RESP;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    dm_rdata_d = bus.mem_rdata;
                    if (state_q == GNT_IF) begin
                        if_ack_d  = 1'b1;
                        if_inst_d = if_sel_q ? bus.mem_rdata[DATA_W-1:INST_W]
                                             : bus.mem_rdata[INST_W-1:0];
                    end else begin
                        dm_ack_d = 1'b1;
                    end
                end
            end

            RESP: begin
                // Requests are not looked at here, so a req still held during its ack cycle cannot re-grant
                state_d    = IDLE;
                grant_dm_d = 1'b0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            if_sel_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            grant_dm_q  <= 1'b0;
            if_inst_q   <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            if_sel_q    <= if_sel_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            grant_dm_q  <= grant_dm_d;
            if_inst_q   <= if_inst_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.if_inst   = if_inst_q;
    assign bus.dm_ack    = dm_ack_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.grant_dm  = grant_dm_q;

endmodule

// File: tb/tb_memport_arbiter.sv
// tb_memport_arbiter: self-checking bench for memport_arbiter.
// Requester processes issue queued fetch/data requests, a memory model answers
// with a programmable wait count, a monitor logs every ack, and per-scenario
// tasks compare logged acks against scoreboard expectations.
module tb_memport_arbiter;
    localparam int unsigned MAXDATA = 4;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
    } dm_req_t;

    typedef struct {
        bit          chk;
        logic [63:0] data;
    } exp_t;

    typedef struct {
        bit          is_dm;
        logic [63:0] data;
        int          cyc;
    } obs_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    memport_arbiter_if bus ();

    memport_arbiter #(.MAXDATA(MAXDATA)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    bit          mem_auto = 1'b1;
    bit          mem_fixed_en = 1'b0;
    logic [63:0] mem_fixed = 64'h0;
    int          mem_wait = 0;
    int          mem_ack_cyc = 0;
    logic [63:0] last_waddr = 64'h0;
    logic [63:0] last_wdata = 64'h0;
    int          both_ack_cnt = 0;
    int          stab_err = 0;
    int          grant_cnt = 0;

    logic [63:0] if_q[$];
    dm_req_t     dm_q[$];
    exp_t        sb_if[$];
    exp_t        sb_dm[$];
    obs_t        obs[$];

    function automatic logic [63:0] mem_fn(input logic [63:0] a);
        return {a[31:0] ^ 32'hC0DE_0000, ~a[31:0]};
    endfunction

    function automatic logic [63:0] exp_inst(input logic [63:0] a);
        logic [63:0] d;
        d = mem_fn({a[63:3], 3'b000});
        return {32'h0, (a[2] ? d[63:32] : d[31:0])};
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory model: acks after mem_wait extra cycles of mem_req
    initial begin : mem_model
        int cnt;
        cnt = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_auto) begin
                if (bus.mem_req) begin
                    if (cnt >= mem_wait) begin
                        bus.mem_ack   = 1'b1;
                        bus.mem_rdata = mem_fixed_en ? mem_fixed : mem_fn(bus.mem_addr);
                        if (bus.mem_we) begin
                            last_waddr = bus.mem_addr;
                            last_wdata = bus.mem_wdata;
                        end
                        mem_ack_cyc = cyc;
                        cnt = 0;
                    end else begin
                        bus.mem_ack = 1'b0;
                        cnt++;
                    end
                end else begin
                    bus.mem_ack = 1'b0;
                    cnt = 0;
                end
            end
        end
    end

    // Fetch requester: holds req until its ack, drops or reloads on the next edge
    initial begin : if_requester
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        forever begin
            @(negedge clk);
            if (bus.if_ack && if_q.size() > 0) if_q.delete(0);
            @(posedge clk);
            #1;
            if (if_q.size() > 0) begin
                bus.if_req  = 1'b1;
                bus.if_addr = if_q[0];
            end else begin
                bus.if_req = 1'b0;
            end
        end
    end

    // Data requester
    initial begin : dm_requester
        bus.dm_req   = 1'b0;
        bus.dm_we    = 1'b0;
        bus.dm_addr  = '0;
        bus.dm_wdata = '0;
        forever begin
            @(negedge clk);
            if (bus.dm_ack && dm_q.size() > 0) dm_q.delete(0);
            @(posedge clk);
            #1;
            if (dm_q.size() > 0) begin
                bus.dm_req   = 1'b1;
                bus.dm_we    = dm_q[0].we;
                bus.dm_addr  = dm_q[0].addr;
                bus.dm_wdata = dm_q[0].wdata;
            end else begin
                bus.dm_req = 1'b0;
            end
        end
    end

    // Monitor: logs acks, counts double acks, unstable memory requests and grants
    initial begin : monitor
        logic        pr;
        logic        pwe;
        logic [63:0] pa;
        logic [63:0] pw;
        pr = 1'b0; pwe = 1'b0; pa = '0; pw = '0;
        forever begin
            @(negedge clk);
            if (bus.if_ack && bus.dm_ack) both_ack_cnt++;
            if (bus.dm_ack) obs.push_back('{is_dm: 1'b1, data: bus.dm_rdata, cyc: cyc});
            else if (bus.if_ack) obs.push_back('{is_dm: 1'b0, data: {32'h0, bus.if_inst}, cyc: cyc});
            if (pr && bus.mem_req && (pa !== bus.mem_addr || pw !== bus.mem_wdata || pwe !== bus.mem_we))
                stab_err++;
            if (bus.mem_req && !pr) grant_cnt++;
            pr  = bus.mem_req;
            pa  = bus.mem_addr;
            pw  = bus.mem_wdata;
            pwe = bus.mem_we;
        end
    end

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++; if ({bus.mem_req, bus.mem_we, bus.if_ack, bus.dm_ack, bus.grant_dm} !== 5'b0) $display("FAIL reset_ctrl: got %b expected 00000", {bus.mem_req, bus.mem_we, bus.if_ack, bus.dm_ack, bus.grant_dm}); else n_pass++;
        n_checks++; if (bus.mem_addr !== 64'h0) $display("FAIL reset_mem_addr: got %h expected 0", bus.mem_addr); else n_pass++;
        n_checks++; if ({bus.mem_wdata, bus.dm_rdata, bus.if_inst} !== 160'h0) $display("FAIL reset_data: got %h %h %h expected 0", bus.mem_wdata, bus.dm_rdata, bus.if_inst); else n_pass++;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.mem_req !== 1'b0) $display("FAIL idle_no_req: got %b expected 0", bus.mem_req); else n_pass++;
    endtask

    task automatic test_lone_fetch();
        bit   ok;
        exp_t e;
        obs.delete();
        mem_fixed_en = 1'b1;
        mem_fixed    = 64'hAAAAAAAA_BBBBBBBB;
        mem_wait     = 0;
        if_q.push_back(64'h104);
        sb_if.push_back('{chk: 1'b1, data: 64'h0000_0000_AAAA_AAAA});
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.if_req) begin ok = 1'b1; break; end
        end
        n_checks++; if (!ok) $display("FAIL fetch_req_timeout: got no if_req expected if_req"); else n_pass++;
        n_checks++; if (bus.mem_req !== 1'b0) $display("FAIL fetch_mem_req_t0: got %b expected 0", bus.mem_req); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.mem_req !== 1'b1) $display("FAIL fetch_mem_req_t1: got %b expected 1", bus.mem_req); else n_pass++;
        n_checks++; if (bus.mem_addr !== 64'h100) $display("FAIL fetch_mem_addr: got %h expected 100", bus.mem_addr); else n_pass++;
        n_checks++; if (bus.mem_we !== 1'b0) $display("FAIL fetch_mem_we: got %b expected 0", bus.mem_we); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.if_ack !== 1'b1) $display("FAIL fetch_ack_t2: got %b expected 1", bus.if_ack); else n_pass++;
        n_checks++; if (bus.if_inst !== 32'hAAAAAAAA) $display("FAIL fetch_inst: got %h expected aaaaaaaa", bus.if_inst); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.if_ack !== 1'b0) $display("FAIL fetch_ack_pulse: got %b expected 0", bus.if_ack); else n_pass++;
        n_checks++; if (obs.size() != 1) $display("FAIL fetch_ack_count: got %0d expected 1", obs.size()); else n_pass++;
        if (obs.size() > 0 && sb_if.size() > 0) begin
            e = sb_if.pop_front();
            n_checks++; if (obs[0].is_dm || obs[0].data !== e.data) $display("FAIL fetch_sb: got dm=%0d %h expected dm=0 %h", obs[0].is_dm, obs[0].data, e.data); else n_pass++;
        end
        mem_fixed_en = 1'b0;
    endtask

    task automatic test_lone_store();
        bit ok;
        int hold;
        int bad;
        int ack_c;
        obs.delete();
        mem_wait = 3;
        dm_q.push_back('{we: 1'b1, addr: 64'h20F, wdata: 64'h1234});
        sb_dm.push_back('{chk: 1'b0, data: 64'h0});
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.dm_req) begin ok = 1'b1; break; end
        end
        hold = 0; bad = 0; ack_c = -100;
        for (int c = 0; c < 20 && ok; c++) begin
            @(negedge clk);
            if (bus.dm_ack) begin
                ack_c = cyc;
                n_checks++; if (bus.grant_dm !== 1'b1) $display("FAIL store_grant_resp: got %b expected 1", bus.grant_dm); else n_pass++;
                break;
            end
            if (bus.mem_req) begin
                hold++;
                if (bus.mem_addr !== 64'h208 || bus.mem_we !== 1'b1 || bus.mem_wdata !== 64'h1234 || bus.grant_dm !== 1'b1) bad++;
                // Change requester inputs after the grant; the memory request must not follow
                if (dm_q.size() > 0) begin
                    dm_q[0].wdata = 64'hFFFF_FFFF;
                    dm_q[0].addr  = 64'h500;
                end
            end
        end
        n_checks++; if (ack_c < 0) $display("FAIL store_ack_timeout: got no dm_ack expected dm_ack"); else n_pass++;
        n_checks++; if (hold != 4) $display("FAIL store_hold: got %0d expected 4", hold); else n_pass++;
        n_checks++; if (bad != 0) $display("FAIL store_stable: got %0d bad cycles expected 0", bad); else n_pass++;
        n_checks++; if (ack_c - mem_ack_cyc != 1) $display("FAIL store_ack_latency: got %0d expected 1", ack_c - mem_ack_cyc); else n_pass++;
        n_checks++; if (last_waddr !== 64'h208 || last_wdata !== 64'h1234) $display("FAIL store_mem_write: got %h %h expected 208 1234", last_waddr, last_wdata); else n_pass++;
        @(negedge clk);
        n_checks++; if ({bus.mem_req, bus.grant_dm, bus.dm_ack} !== 3'b0) $display("FAIL store_idle: got %b expected 000", {bus.mem_req, bus.grant_dm, bus.dm_ack}); else n_pass++;
        if (sb_dm.size() > 0) void'(sb_dm.pop_front());
        n_checks++; if (obs.size() != 1 || !obs[0].is_dm) $display("FAIL store_sb: got %0d acks expected 1 data ack", obs.size()); else n_pass++;
        mem_wait = 0;
    endtask

    task automatic test_reset_mid_access();
        bit   ok;
        exp_t e;
        obs.delete();
        mem_auto = 1'b0;
        dm_q.push_back('{we: 1'b1, addr: 64'h3F8, wdata: 64'hDEAD});
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (bus.grant_dm) begin ok = 1'b1; break; end
        end
        n_checks++; if (!ok || bus.mem_addr !== 64'h3F8) $display("FAIL rstmid_grant: got ok=%0d addr=%h expected 1 3f8", ok, bus.mem_addr); else n_pass++;
        repeat (2) @(posedge clk);
        #3;
        dm_q.delete();
        rst = 1'b0;
        #1;
        n_checks++; if ({bus.mem_req, bus.mem_we, bus.if_ack, bus.dm_ack, bus.grant_dm} !== 5'b0) $display("FAIL rstmid_ctrl: got %b expected 00000", {bus.mem_req, bus.mem_we, bus.if_ack, bus.dm_ack, bus.grant_dm}); else n_pass++;
        n_checks++; if ({bus.mem_addr, bus.mem_wdata, bus.dm_rdata, bus.if_inst} !== 224'h0) $display("FAIL rstmid_data: got %h %h %h %h expected 0", bus.mem_addr, bus.mem_wdata, bus.dm_rdata, bus.if_inst); else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1; bus.mem_ack = 1'b1;
        @(posedge clk); #1; bus.mem_ack = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++; if (obs.size() != 0 || bus.mem_req !== 1'b0) $display("FAIL rstmid_late_ack: got %0d acks mem_req=%b expected 0 0", obs.size(), bus.mem_req); else n_pass++;
        mem_auto = 1'b1;
        if_q.push_back(64'h40);
        sb_if.push_back('{chk: 1'b1, data: exp_inst(64'h40)});
        for (int c = 0; c < 20 && obs.size() < 1; c++) @(posedge clk);
        n_checks++; if (obs.size() != 1) $display("FAIL rstmid_next_fetch: got %0d acks expected 1", obs.size()); else n_pass++;
        if (obs.size() > 0 && sb_if.size() > 0) begin
            e = sb_if.pop_front();
            n_checks++; if (obs[0].is_dm || obs[0].data !== e.data) $display("FAIL rstmid_fetch_data: got dm=%0d %h expected dm=0 %h", obs[0].is_dm, obs[0].data, e.data); else n_pass++;
        end
    endtask

    task automatic test_contested();
        bit   ok;
        exp_t e;
        repeat (2) @(negedge clk);
        obs.delete();
        mem_wait = 0;
        if_q.push_back(64'h1000);
        dm_q.push_back('{we: 1'b0, addr: 64'h2008, wdata: 64'h0});
        sb_if.push_back('{chk: 1'b1, data: exp_inst(64'h1000)});
        sb_dm.push_back('{chk: 1'b1, data: mem_fn(64'h2008)});
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.if_req && bus.dm_req) begin ok = 1'b1; break; end
        end
        @(negedge clk);
        n_checks++; if (!ok || bus.grant_dm !== 1'b1 || bus.mem_addr !== 64'h2008) $display("FAIL tie_grant: got grant_dm=%b addr=%h expected 1 2008", bus.grant_dm, bus.mem_addr); else n_pass++;
        for (int c = 0; c < 30 && obs.size() < 2; c++) @(posedge clk);
        n_checks++; if (obs.size() != 2) $display("FAIL tie_ack_count: got %0d expected 2", obs.size()); else n_pass++;
        if (obs.size() >= 2) begin
            e = sb_dm.pop_front();
            n_checks++; if (!obs[0].is_dm || obs[0].data !== e.data) $display("FAIL tie_first_dm: got dm=%0d %h expected dm=1 %h", obs[0].is_dm, obs[0].data, e.data); else n_pass++;
            e = sb_if.pop_front();
            n_checks++; if (obs[1].is_dm || obs[1].data !== e.data) $display("FAIL tie_second_if: got dm=%0d %h expected dm=0 %h", obs[1].is_dm, obs[1].data, e.data); else n_pass++;
            n_checks++; if (obs[1].cyc - obs[0].cyc != 3) $display("FAIL tie_fetch_next_idle: got %0d cycles expected 3", obs[1].cyc - obs[0].cyc); else n_pass++;
        end
    endtask

    task automatic test_starvation();
        exp_t e;
        bit   exp_dm;
        repeat (2) @(negedge clk);
        obs.delete();
        mem_wait = 1;
        for (int i = 0; i < 12; i++) begin
            dm_q.push_back('{we: 1'b0, addr: 64'h8000 + 64'(8 * i), wdata: 64'h0});
            sb_dm.push_back('{chk: 1'b1, data: mem_fn(64'h8000 + 64'(8 * i))});
        end
        for (int i = 0; i < 3; i++) begin
            if_q.push_back(64'h4000 + 64'(4 * i));
            sb_if.push_back('{chk: 1'b1, data: exp_inst(64'h4000 + 64'(4 * i))});
        end
        for (int c = 0; c < 300 && obs.size() < 15; c++) @(posedge clk);
        n_checks++; if (obs.size() != 15) $display("FAIL starve_ack_count: got %0d expected 15", obs.size()); else n_pass++;
        for (int i = 0; i < 15 && i < obs.size(); i++) begin
            exp_dm = ((i % (MAXDATA + 1)) != MAXDATA);
            n_checks++; if (obs[i].is_dm != exp_dm) $display("FAIL starve_order[%0d]: got dm=%0d expected dm=%0d", i, obs[i].is_dm, exp_dm); else n_pass++;
            if (obs[i].is_dm && sb_dm.size() > 0) e = sb_dm.pop_front();
            else if (!obs[i].is_dm && sb_if.size() > 0) e = sb_if.pop_front();
            else e = '{chk: 1'b1, data: 64'hX};
            n_checks++; if (obs[i].data !== e.data) $display("FAIL starve_data[%0d]: got %h expected %h", i, obs[i].data, e.data); else n_pass++;
        end
        sb_dm.delete();
        sb_if.delete();
        mem_wait = 0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   g0;
        repeat (3) @(negedge clk);
        obs.delete();
        mem_wait = 0;
        g0 = grant_cnt;
        for (int i = 0; i < 3; i++) begin
            dm_q.push_back('{we: 1'b0, addr: 64'hA000 + 64'(16 * i), wdata: 64'h0});
            sb_dm.push_back('{chk: 1'b1, data: mem_fn(64'hA000 + 64'(16 * i))});
        end
        for (int c = 0; c < 40 && obs.size() < 3; c++) @(posedge clk);
        repeat (6) @(posedge clk);
        n_checks++; if (obs.size() != 3) $display("FAIL b2b_ack_count: got %0d expected 3", obs.size()); else n_pass++;
        n_checks++; if (grant_cnt - g0 != 3) $display("FAIL b2b_grant_count: got %0d expected 3", grant_cnt - g0); else n_pass++;
        for (int i = 0; i < 3 && i < obs.size(); i++) begin
            e = sb_dm.pop_front();
            n_checks++; if (!obs[i].is_dm || obs[i].data !== e.data) $display("FAIL b2b_data[%0d]: got dm=%0d %h expected dm=1 %h", i, obs[i].is_dm, obs[i].data, e.data); else n_pass++;
            if (i > 0) begin
                n_checks++; if (obs[i].cyc - obs[i-1].cyc != 3) $display("FAIL b2b_spacing[%0d]: got %0d expected 3", i, obs[i].cyc - obs[i-1].cyc); else n_pass++;
            end
        end
        sb_dm.delete();
    endtask

    task automatic test_invariants();
        n_checks++; if (both_ack_cnt != 0) $display("FAIL inv_both_acks: got %0d expected 0", both_ack_cnt); else n_pass++;
        n_checks++; if (stab_err != 0) $display("FAIL inv_mem_stable: got %0d expected 0", stab_err); else n_pass++;
    endtask

    initial begin
        rst = 1'b0;
        test_reset();
        test_lone_fetch();
        test_lone_store();
        test_reset_mid_access();
        test_contested();
        test_starvation();
        test_back_to_back();
        test_invariants();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
